pred_update_ctrl: RTL and testbench

- Sequences the two-level branch predictor tables.
- After reset or soft clear, runs a one-entry-per-cycle clear sweep.
- Buffers ROB commit-time branch outcomes in a small FIFO.
- Arbitrates the single table port between IF lookups and queued updates: lookups win by default; updates win when the FIFO is full or after bounded starvation.

---
 rtl/pred_update_ctrl_pkg.sv | 27 ++
 rtl/pred_upd_fifo.sv | 71 +++++++
 rtl/pred_update_ctrl.sv | 141 ++++++++++++++
 tb/tb_pred_update_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pred_update_ctrl_pkg.sv
// Shared definitions for the branch-predictor update controller.
// Holds table geometry, queue sizing, FSM encodings and the update record
// layout used by pred_update_ctrl and its pending-update FIFO.
package pred_update_ctrl_pkg;

  localparam int ADDR_WIDTH   = 32;
  localparam int PHT_WIDTH    = 6;
  localparam int PHT_SIZE     = 2 ** PHT_WIDTH;
  localparam int FIFO_DEPTH   = 4;
  localparam int STARVE_LIMIT = 3;

  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int STARVE_W  = $clog2(STARVE_LIMIT + 1);
  localparam int UPD_REC_W = ADDR_WIDTH + 1;

  typedef enum logic {
    PRED_INIT = 1'b0,
    PRED_RUN  = 1'b1
  } pred_state_e;

  // One committed branch outcome waiting to be written into the tables.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  taken;
  } upd_rec_t;

endpackage

// File: rtl/pred_upd_fifo.sv
// Synchronous FIFO for pending predictor updates.
// Ports:
//   clk, rst_n        clock / asynchronous active-low reset
//   en                global enable; low freezes all state
//   push, wdata       write an entry (ignored when full)
//   pop               retire the head (ignored when empty)
//   flush             drop all entries; wins over push/pop in the same cycle
//   rdata             head entry (undefined when empty)
//   count             number of stored entries
//   empty, full       occupancy flags
module pred_upd_fifo
  import pred_update_ctrl_pkg::*;
#(
  parameter int WIDTH = UPD_REC_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign do_push = en && push && !full && !flush;
  assign do_pop  = en && pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array has no reset; occupancy is tracked by count and
  // the pointers, so stale contents are never observed as valid entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (en && flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pred_update_ctrl.sv
// Branch-predictor table sequencer.
// After reset or soft_clear it sweeps every table row once (one per ready
// cycle), then arbitrates the single table port between IF lookups and
// queued ROB commit updates. Lookups win unless the update queue is full or
// has lost STARVE_LIMIT cycles in a row.
// Ports:
//   clk, rst_in                     clock / asynchronous active-low reset
//   rdy_in                          global ready; low freezes all state
//   soft_clear                      restart sweep, drop queued updates
//   rob_upd_valid/pc/taken          committed branch outcome from the ROB
//   rob_upd_ready                   queue accepts a push this cycle
//   if_lookup_req / if_lookup_gnt   IF table-port request / grant
//   pred_upd_en/pc/taken            apply queue-head update to the tables
//   pred_clr_en / pred_clr_idx      clear one table row during the sweep
//   ctrl_busy                       sweep in progress
//   fifo_count                      queued updates
module pred_update_ctrl
  import pred_update_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  soft_clear,
  input  logic                  rob_upd_valid,
  input  logic [ADDR_WIDTH-1:0] rob_upd_pc,
  input  logic                  rob_upd_taken,
  output logic                  rob_upd_ready,
  input  logic                  if_lookup_req,
  output logic                  if_lookup_gnt,
  output logic                  pred_upd_en,
  output logic [ADDR_WIDTH-1:0] pred_upd_pc,
  output logic                  pred_upd_taken,
  output logic                  pred_clr_en,
  output logic [PHT_WIDTH-1:0]  pred_clr_idx,
  output logic                  ctrl_busy,
  output logic [CNT_W-1:0]      fifo_count
);

  pred_state_e          state_q, state_d;
  logic [PHT_WIDTH-1:0] clr_idx_q, clr_idx_d;
  logic [STARVE_W-1:0]  starve_q, starve_d;

  logic     fifo_empty;
  logic     fifo_full;
  logic     upd_win;
  upd_rec_t push_rec;
  upd_rec_t head_rec;

  assign push_rec = '{pc: rob_upd_pc, taken: rob_upd_taken};

  // The queue only holds entries in RUN, so the state term is defensive.
  assign upd_win = (state_q == PRED_RUN) && !fifo_empty &&
                   (!if_lookup_req || fifo_full ||
                    starve_q == STARVE_W'(STARVE_LIMIT));

  pred_upd_fifo #(
    .WIDTH (UPD_REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_in),
    .en    (rdy_in),
    .push  (rob_upd_valid && rob_upd_ready),
    .pop   (pred_upd_en),
    .flush (soft_clear),
    .wdata (push_rec),
    .rdata (head_rec),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= PRED_INIT;
      clr_idx_q <= '0;
      starve_q  <= '0;
    end else if (rdy_in) begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      starve_q  <= starve_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    starve_d  = starve_q;
    if (soft_clear) begin
      state_d   = PRED_INIT;
      clr_idx_d = '0;
      starve_d  = '0;
    end else begin
      case (state_q)
        PRED_INIT: begin
          if (clr_idx_q == PHT_WIDTH'(PHT_SIZE - 1)) begin
            state_d   = PRED_RUN;
            clr_idx_d = '0;
          end else begin
            clr_idx_d = clr_idx_q + 1'b1;
          end
        end
        PRED_RUN: begin
          // A non-empty queue that does not win has lost to an IF lookup.
          if (fifo_empty || upd_win)
            starve_d = '0;
          else if (starve_q != STARVE_W'(STARVE_LIMIT))
            starve_d = starve_q + 1'b1;
        end
        default: state_d = PRED_INIT;
      endcase
    end
  end

  always_comb begin
    rob_upd_ready = 1'b0;
    if_lookup_gnt = 1'b0;
    pred_upd_en   = 1'b0;
    pred_clr_en   = 1'b0;
    ctrl_busy     = (state_q != PRED_RUN);
    pred_clr_idx  = clr_idx_q;
    case (state_q)
      // rst_in gating keeps the clear strobe quiet while reset is held.
      PRED_INIT: pred_clr_en = rdy_in && rst_in;
      PRED_RUN: begin
        rob_upd_ready = rdy_in && !fifo_full;
        pred_upd_en   = rdy_in && upd_win;
        if_lookup_gnt = rdy_in && if_lookup_req && !upd_win;
      end
      default: ;
    endcase
  end

  assign pred_upd_pc    = head_rec.pc;
  assign pred_upd_taken = head_rec.taken;

endmodule

// File: tb/tb_pred_update_ctrl.sv
// Self-checking bench for pred_update_ctrl against a queue-based model.
module tb_pred_update_ctrl;
  import pred_update_ctrl_pkg::*;

  logic                  clk;
  logic                  rst_in;
  logic                  rdy_in;
  logic                  soft_clear;
  logic                  rob_upd_valid;
  logic [ADDR_WIDTH-1:0] rob_upd_pc;
  logic                  rob_upd_taken;
  logic                  rob_upd_ready;
  logic                  if_lookup_req;
  logic                  if_lookup_gnt;
  logic                  pred_upd_en;
  logic [ADDR_WIDTH-1:0] pred_upd_pc;
  logic                  pred_upd_taken;
  logic                  pred_clr_en;
  logic [PHT_WIDTH-1:0]  pred_clr_idx;
  logic                  ctrl_busy;
  logic [CNT_W-1:0]      fifo_count;

  pred_update_ctrl dut (
    .clk            (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .soft_clear     (soft_clear),
    .rob_upd_valid  (rob_upd_valid),
    .rob_upd_pc     (rob_upd_pc),
    .rob_upd_taken  (rob_upd_taken),
    .rob_upd_ready  (rob_upd_ready),
    .if_lookup_req  (if_lookup_req),
    .if_lookup_gnt  (if_lookup_gnt),
    .pred_upd_en    (pred_upd_en),
    .pred_upd_pc    (pred_upd_pc),
    .pred_upd_taken (pred_upd_taken),
    .pred_clr_en    (pred_clr_en),
    .pred_clr_idx   (pred_clr_idx),
    .ctrl_busy      (ctrl_busy),
    .fifo_count     (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending updates as a queue, sweep as a flag + position,
  // starvation as a count of consecutive lost cycles.
  upd_rec_t mq[$];
  bit       m_sweep;
  int       m_pos;
  int       m_streak;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_sweep  = 1'b1;
    m_pos    = 0;
    m_streak = 0;
  endtask

  function automatic bit model_upd_wins();
    int sz = mq.size();
    return (sz > 0) && (!if_lookup_req || sz == FIFO_DEPTH || m_streak == STARVE_LIMIT);
  endfunction

  task automatic check_all();
    int sz      = mq.size();
    bit wins    = model_upd_wins();
    bit running = rst_in && !m_sweep;
    check("busy",    ctrl_busy,     64'(m_sweep));
    check("clr_en",  pred_clr_en,   64'(rst_in && rdy_in && m_sweep));
    if (m_sweep) check("clr_idx", pred_clr_idx, 64'(m_pos));
    check("ready",   rob_upd_ready, 64'(rdy_in && running && sz < FIFO_DEPTH));
    check("upd_en",  pred_upd_en,   64'(rdy_in && running && wins));
    check("gnt",     if_lookup_gnt, 64'(rdy_in && running && if_lookup_req && !wins));
    check("count",   fifo_count,    64'(sz));
    if (sz > 0) begin
      check("head_pc",    pred_upd_pc,    64'(mq[0].pc));
      check("head_taken", pred_upd_taken, 64'(mq[0].taken));
    end
  endtask

  // Advance the model by one clock edge using the inputs held across it.
  task automatic model_step();
    int sz;
    bit wins;
    if (!rst_in) begin
      model_reset();
    end else if (rdy_in) begin
      if (soft_clear) begin
        model_reset();
      end else if (m_sweep) begin
        if (m_pos == PHT_SIZE - 1) begin
          m_sweep = 1'b0;
          m_pos   = 0;
        end else begin
          m_pos++;
        end
      end else begin
        sz   = mq.size();
        wins = model_upd_wins();
        if (sz == 0 || wins) m_streak = 0;
        else if (m_streak < STARVE_LIMIT) m_streak++;
        if (wins) void'(mq.pop_front());
        if (rob_upd_valid && sz < FIFO_DEPTH)
          mq.push_back('{pc: rob_upd_pc, taken: rob_upd_taken});
      end
    end
  endtask

  // Compare mid-cycle, take the edge, update the model, settle past the edge.
  task automatic tick();
    #2;
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst_in        = 1'b0;
    rdy_in        = 1'b1;
    soft_clear    = 1'b0;
    rob_upd_valid = 1'b0;
    rob_upd_pc    = '0;
    rob_upd_taken = 1'b0;
    if_lookup_req = 1'b1;
    model_reset();

    // Reset state, with IF requesting to show the grant stays low.
    #3;
    check("rst_busy",   ctrl_busy,     64'd1);
    check("rst_clr_en", pred_clr_en,   64'd0);
    check("rst_ready",  rob_upd_ready, 64'd0);
    check("rst_gnt",    if_lookup_gnt, 64'd0);
    check("rst_count",  fifo_count,    64'd0);
    @(posedge clk); #1;
    tick();

    // Release: 64-cycle sweep over idx 0..63, then RUN.
    rst_in        = 1'b1;
    if_lookup_req = 1'b0;
    #1;
    check("sweep_first_idx", pred_clr_idx, 64'd0);
    check("sweep_first_en",  pred_clr_en,  64'd1);
    for (int i = 0; i < PHT_SIZE; i++) tick();
    #1;
    check("run_busy",  ctrl_busy,     64'd0);
    check("run_ready", rob_upd_ready, 64'd1);

    // Single push with IF idle: head pops on the following cycle.
    rob_upd_valid = 1'b1;
    rob_upd_pc    = 32'h104;
    rob_upd_taken = 1'b1;
    tick();
    rob_upd_valid = 1'b0;
    #1;
    check("upd1_en",    pred_upd_en,    64'd1);
    check("upd1_pc",    pred_upd_pc,    64'h104);
    check("upd1_taken", pred_upd_taken, 64'd1);
    tick();
    #1;
    check("upd1_drained", fifo_count, 64'd0);

    // Starvation: IF wins three cycles, the update takes the fourth.
    if_lookup_req = 1'b1;
    rob_upd_valid = 1'b1;
    rob_upd_pc    = 32'h200;
    rob_upd_taken = 1'b0;
    tick();
    rob_upd_valid = 1'b0;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      #1;
      check("starve_gnt",    if_lookup_gnt, 64'd1);
      check("starve_no_upd", pred_upd_en,   64'd0);
      tick();
    end
    #1;
    check("starve_upd", pred_upd_en,   64'd1);
    check("starve_gnt_off", if_lookup_gnt, 64'd0);
    tick();

    // Fill to FIFO_DEPTH with IF requesting: full queue wins the port.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      rob_upd_valid = 1'b1;
      rob_upd_pc    = 32'h300 + 32'(4 * i);
      rob_upd_taken = i[0];
      tick();
    end
    rob_upd_valid = 1'b0;
    #1;
    check("full_count", fifo_count,    64'(FIFO_DEPTH));
    check("full_ready", rob_upd_ready, 64'd0);
    check("full_upd",   pred_upd_en,   64'd1);
    check("full_gnt",   if_lookup_gnt, 64'd0);
    if_lookup_req = 1'b0;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) tick();

    // soft_clear with three entries queued; the same-cycle push is lost.
    if_lookup_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rob_upd_valid = 1'b1;
      rob_upd_pc    = 32'h400 + 32'(4 * i);
      rob_upd_taken = 1'b1;
      tick();
    end
    #1;
    check("pre_clear_count", fifo_count, 64'd3);
    soft_clear = 1'b1;
    rob_upd_pc = 32'h999;
    tick();
    soft_clear    = 1'b0;
    rob_upd_valid = 1'b0;
    if_lookup_req = 1'b0;
    #1;
    check("clear_count", fifo_count,   64'd0);
    check("clear_busy",  ctrl_busy,    64'd1);
    check("clear_idx",   pred_clr_idx, 64'd0);

    // Freeze mid-sweep at idx 20 for five cycles, then resume.
    for (int i = 0; i < 20; i++) tick();
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("frozen_clr_en", pred_clr_en,  64'd0);
      check("frozen_idx",    pred_clr_idx, 64'd20);
      tick();
    end
    rdy_in = 1'b1;
    #1;
    check("resume_idx", pred_clr_idx, 64'd20);
    check("resume_en",  pred_clr_en,  64'd1);
    for (int i = 0; i < PHT_SIZE - 20; i++) tick();

    // Randomized traffic checked against the model every cycle.
    for (int i = 0; i < 600; i++) begin
      rdy_in        = ($urandom % 8) != 0;
      soft_clear    = ($urandom % 80) == 0;
      rob_upd_valid = $urandom % 2;
      rob_upd_pc    = $urandom;
      rob_upd_taken = $urandom % 2;
      if_lookup_req = ($urandom % 3) != 0;
      tick();
    end
    rdy_in        = 1'b1;
    soft_clear    = 1'b0;
    rob_upd_valid = 1'b0;
    if_lookup_req = 1'b0;
    for (int i = 0; i < PHT_SIZE + 2; i++) tick();

    // Async reset mid-run with entries queued.
    if_lookup_req = 1'b1;
    rob_upd_valid = 1'b1;
    rob_upd_pc    = 32'h500;
    tick();
    tick();
    rob_upd_valid = 1'b0;
    rst_in = 1'b0;
    #1;
    model_reset();
    check("arst_busy",   ctrl_busy,     64'd1);
    check("arst_count",  fifo_count,    64'd0);
    check("arst_clr_en", pred_clr_en,   64'd0);
    check("arst_gnt",    if_lookup_gnt, 64'd0);
    tick();
    rst_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
